// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants, FSM states and FIFO entry type for the fetch stage
package fetch_pkg;
  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;
  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of {pc, inst} pairs; flush wins over push
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fetch_entry_t                 i_data,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    o_empty = cnt_q == '0;
    o_full = cnt_q == CW'(DEPTH);
    o_count = cnt_q;
    o_head = mem_q[rd_q];
    do_pop = i_pop & ~o_empty;
    do_push = i_push & (~o_full | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = i_data;
    rd_d = i_flush ? '0 : do_pop ? inc(rd_q) : rd_q;
    wr_d = i_flush ? '0 : do_push ? inc(wr_q) : wr_q;
    cnt_d = i_flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge i_clk) mem_q <= mem_d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, one-outstanding imem handshake and {pc, inst} buffering ahead of IF/ID
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_imemReq,
  output logic [INST_ADDR_BUS-1:0] o_imemAddr,
  input  logic                     i_imemAck,
  input  logic [INST_BUS-1:0]      i_imemData,
  input  logic                     i_stall,
  input  logic                     i_takeBranch,
  input  logic [INST_ADDR_BUS-1:0] i_jpc,
  output logic                     o_valid,
  output logic [INST_ADDR_BUS-1:0] o_pc,
  output logic [INST_BUS-1:0]      o_inst
);
  localparam int CW = $clog2(DEPTH+1);
  fetch_state_e state_q, state_d;
  logic [INST_ADDR_BUS-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d;
  logic req_q, req_d;
  logic redirect, push, pop, issue, full, empty;
  logic [CW-1:0] count;
  fetch_entry_t head, wr_entry;
  always_comb begin
    redirect = i_takeBranch & ~i_stall;
    pop = ~empty & ~i_stall & ~redirect;
    push = (state_q == FETCH_WAIT) & i_imemAck & ~redirect;
    wr_entry = '{pc: addr_q, inst: i_imemData};
    issue = redirect | pop | ~(full | (push & (count == CW'(DEPTH-1))));
    fetch_pc_d = redirect ? i_jpc & ~32'd3 : push ? addr_q + 32'd4 : fetch_pc_q;
    state_d = state_q;
    req_d = req_q;
    addr_d = addr_q;
    if (state_q == FETCH_IDLE || i_imemAck) begin
      state_d = issue ? FETCH_WAIT : FETCH_IDLE;
      req_d = issue ? ENABLE : DISABLE;
      addr_d = issue ? fetch_pc_d : addr_q;
    end else if (redirect) begin
      state_d = FETCH_DROP;
    end
    o_imemReq = req_q;
    o_imemAddr = addr_q;
    o_valid = ~empty;
    o_pc = empty ? ZERO_WORD : head.pc;
    o_inst = empty ? ZERO_WORD : head.inst;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC & ~32'd3;
      req_q <= DISABLE;
      addr_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q <= req_d;
      addr_q <= addr_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (redirect),
    .i_data  (wr_entry),
    .o_head  (head),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage ahead of the IF/ID register. Keeps the fetch PC, runs a one-outstanding request/acknowledge handshake with instruction memory, and buffers fetched {pc, inst} pairs in a small FIFO. Presents the oldest pair to IF/ID. Accepts stall and branch-redirect from the decode stage, with no delay slot: the instruction after a taken branch or jump is squashed.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: FIFO entries, at least 2.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `o_imemReq`  out  1  fetch request, registered.
- `o_imemAddr`  out  32  fetch address, registered; bits [1:0] always 0.
- `i_imemAck`  in  1  memory accepts the request; data is valid in the same cycle.
- `i_imemData`  in  32  fetched instruction word.
- `i_stall`  in  1  IF/ID holds its contents; no pop this cycle.
- `i_takeBranch`  in  1  decode-stage redirect (the decode stage's take-branch output).
- `i_jpc`  in  32  redirect target (the decode stage's jump-PC output).
- `o_valid`  out  1  FIFO not empty.
- `o_pc`  out  32  PC of the FIFO head; 0 when empty.
- `o_inst`  out  32  instruction at the FIFO head; 0 (NOP) when empty.

## Operation
- Registers:
  - `fetchPC`: next address to request.
  - `o_imemAddr`: the address currently held on the memory bus.
  - FIFO entries and `count`.
  - FSM state: IDLE, WAIT or DROP.
- Redirect is effective when `i_takeBranch & ~i_stall`. It is ignored while `i_stall`=1, because decode re-asserts it once the stall releases.
- Pop happens when `o_valid & ~i_stall & ~redirect`. The FIFO pushes when an ack arrives in WAIT and there is no redirect in the same cycle. Push and pop in the same cycle are legal, and `count` is then unchanged.
- A redirect flushes all FIFO entries (`count` goes to 0) and loads `fetchPC` with {`i_jpc`[31:2], 2'b00}.
- FSM:
  - IDLE, no request outstanding: if the next-cycle `count` is below `DEPTH`, raise `o_imemReq`, drive `o_imemAddr`=`fetchPC`, and go to WAIT. Otherwise stay in IDLE.
  - WAIT, request outstanding and its response is wanted:
    - On ack without redirect: push {`o_imemAddr`, `i_imemData`} and set `fetchPC` = `o_imemAddr`+4. Then re-issue immediately if there is room, otherwise go to IDLE.
    - On ack with redirect: discard the data and issue to the new `fetchPC` on the next cycle.
    - Redirect without ack: go to DROP.
  - DROP, request outstanding and its response is to be discarded: keep `o_imemReq` and `o_imemAddr` unchanged. On ack, discard the data and issue to `fetchPC` next cycle. Another redirect in DROP only updates `fetchPC`.
- Handshake rule: once `o_imemReq` is raised, it and `o_imemAddr` stay stable until the ack. A request is raised only when a slot is guaranteed free, so every wanted response finds room.
- `fetchPC` increments modulo 2^32; 0xFFFF_FFFC wraps to 0.

## Timing
- Reset (`i_rst_n`=0 at an edge):
  - State IDLE, `count`=0, `fetchPC`=`RESET_PC`.
  - `o_imemReq`=0 and `o_imemAddr`=0.
  - `o_valid`=0, `o_pc`=0, `o_inst`=0.
  - Reset mid-request abandons the request; memory must tolerate the request dropping.
- First request: asserted in the first cycle after the first edge with `i_rst_n`=1.
- Latency: with an ack in cycle N, the instruction appears on `o_valid`/`o_pc`/`o_inst` in cycle N+1, and the next request is on the bus in N+1.
- Throughput: zero-wait memory with no stall sustains one instruction per cycle.
- Redirect at edge E: FIFO empty and `o_valid`=0 from E. The request to the target appears at E when idle, or one cycle after the discarded ack otherwise. The target instruction is valid one cycle after its ack.
- Stall while the FIFO is full: no request is issued and the head output holds.

## Structure
- Shared defines (existing global header):
  - `INST_ADDR_BUS`, `INST_BUS`, `ZERO_WORD`, `ENABLE`/`DISABLE`.
  - New constants: `RESET_PC` default and the FSM state encodings `FETCH_IDLE`, `FETCH_WAIT`, `FETCH_DROP`.
- Sub-module `fetch_fifo`: parameterised `DEPTH` entries of 64-bit {pc, inst}, with push/pop/flush ports and `count`/full/empty outputs, where flush has priority over push.
- The FSM, PC and handshake logic live in `fetch_unit`.

## Test plan
- Reset, then zero-wait ack every cycle with `RESET_PC`=0 → requests to 0x0, 0x4, 0x8 on consecutive cycles; `o_pc` = 0x0, 0x4, 0x8 one cycle after each ack, `o_valid` held 1.
- Ack delayed 3 cycles on address 0x4 → `o_imemReq` and `o_imemAddr`=0x4 stable for all 3 cycles; exactly one push; `o_valid`=0 while waiting with the FIFO empty.
- `i_stall`=1 for 5 cycles with zero-wait memory → FIFO fills to `DEPTH` and `o_imemReq` drops; `o_pc` held. On release, pops resume with no instruction lost or duplicated.
- Redirect to 0x100 while the request for 0x8 is outstanding, acked 2 cycles later → FIFO flushed, data for 0x8 never appears, next request is 0x100, `o_pc`=0x100 next.
- Redirect with `i_stall`=1 → ignored (FIFO and `fetchPC` unchanged). Redirect with ack in the same cycle → that data is dropped.
- `i_jpc`=0xFFFF_FFFE, then acks → first request is 0xFFFF_FFFC, next request is 0x0000_0000; asserting `i_rst_n`=0 while in WAIT → all outputs 0 at the next edge.
